// File: rtl/sram_seq_pkg.sv
// Shared definitions for the SRAM access sequencer: state encoding and
// bitline pair index helpers.
package sram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    RELEASE = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam int CNT_W = 4;

  // Each data bit i drives a true/complement bitline pair.
  function automatic int bl_d_idx(input int i);
    return 2 * i;
  endfunction

  function automatic int bl_n_idx(input int i);
    return 2 * i + 1;
  endfunction

endpackage

// File: rtl/sram_wl_decode.sv
// One-hot word-line decoder; all lines low whenever the enable is low.
module sram_wl_decode #(
  parameter  int ADDR_W = 2,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  wl
);

  always_comb begin
    wl = '0;
    if (en) wl[addr] = 1'b1;
  end

endmodule

// File: rtl/sram_seq.sv
// SRAM access sequencer: one request at a time, ordered bitline setup,
// word-line pulse and release, with a valid/ready read response.
//
// state   | meaning
// IDLE    | ready for a request
// SETUP   | bitlines driven (write) or released (read), word line low
// ACCESS  | selected word line high for ACC_CYC cycles
// RELEASE | word line low, bitlines still held
// RESP    | read data presented until rsp_ready
module sram_seq
  import sram_seq_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int ADDR_W  = 2,
  parameter  int ACC_CYC = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic [DEPTH-1:0]   wl,
  output logic [2*WIDTH-1:0] bl,
  output logic               bl_oe,
  input  logic [WIDTH-1:0]   sense
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              hold_we;
  logic [ADDR_W-1:0] hold_addr;
  logic              acc_last;

  assign acc_last = (cnt == CNT_LAST);

  function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] d);
    logic [2*WIDTH-1:0] e;
    e = '0;
    for (int i = 0; i < WIDTH; i++) begin
      e[bl_d_idx(i)] = d[i];
      e[bl_n_idx(i)] = ~d[i];
    end
    return e;
  endfunction

  // Gating with rst_n drops the word line the instant reset asserts.
  sram_wl_decode #(.ADDR_W(ADDR_W)) u_wl_decode (
    .en   ((state == ACCESS) & rst_n),
    .addr (hold_addr),
    .wl   (wl)
  );

  // The bl register doubles as the write-data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_we   <= 1'b0;
      hold_addr <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bl        <= '0;
      bl_oe     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            hold_we   <= req_we;
            hold_addr <= req_addr;
            req_ready <= 1'b0;
            bl_oe     <= req_we;
            bl        <= req_we ? encode(req_wdata) : '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (acc_last) begin
            if (!hold_we) rsp_rdata <= sense;
            state <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          bl    <= '0;
          bl_oe <= 1'b0;
          if (hold_we) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_seq.sv
// Scoreboard bench for sram_seq: two instances (ACC_CYC = 1 and 3) over a
// behavioural cell array, random and directed traffic against a reference memory.
module tb_sram_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel;
  int         acc;
  logic       req_valid, req_we, rsp_ready;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;

  logic        req_ready1, rsp_valid1, bl_oe1, req_ready3, rsp_valid3, bl_oe3;
  logic [7:0]  rsp_rdata1, sense1, rsp_rdata3, sense3;
  logic [3:0]  wl1, wl3;
  logic [15:0] bl1, bl3;

  sram_seq #(.WIDTH(8), .ADDR_W(2), .ACC_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
    .wl(wl1), .bl(bl1), .bl_oe(bl_oe1), .sense(sense1)
  );

  sram_seq #(.WIDTH(8), .ADDR_W(2), .ACC_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(req_ready3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
    .wl(wl3), .bl(bl3), .bl_oe(bl_oe3), .sense(sense3)
  );

  logic        req_ready_m, rsp_valid_m, bl_oe_m;
  logic [7:0]  rsp_rdata_m;
  logic [3:0]  wl_m;
  logic [15:0] bl_m;
  assign req_ready_m = sel ? req_ready3 : req_ready1;
  assign rsp_valid_m = sel ? rsp_valid3 : rsp_valid1;
  assign rsp_rdata_m = sel ? rsp_rdata3 : rsp_rdata1;
  assign bl_oe_m     = sel ? bl_oe3 : bl_oe1;
  assign wl_m        = sel ? wl3 : wl1;
  assign bl_m        = sel ? bl3 : bl1;

  // Behavioural cells: a selected row stores the true rail of every
  // complementary pair while the bitlines are driven.
  logic [7:0] cells1 [4];
  logic [7:0] cells3 [4];
  logic [7:0] junk;

  function automatic logic [7:0] cell_upd(input logic [7:0] old, input logic [15:0] b);
    logic [7:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (b[2*i] != b[2*i+1]) r[i] = b[2*i];
    return r;
  endfunction

  always @(posedge clk) begin
    junk <= 8'($urandom);
    for (int r = 0; r < 4; r++) begin
      if (wl1[r] && bl_oe1) cells1[r] <= cell_upd(cells1[r], bl1);
      if (wl3[r] && bl_oe3) cells3[r] <= cell_upd(cells3[r], bl3);
    end
  end

  always_comb begin
    sense1 = junk;
    sense3 = junk;
    for (int r = 0; r < 4; r++) begin
      if (wl1[r]) sense1 = cells1[r];
      if (wl3[r]) sense3 = cells3[r];
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] ref_mem [2][4];
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Differential pair for each bit: 1 -> {~d,d} = 2'b01, 0 -> 2'b10.
  function automatic logic [15:0] tb_encode(input logic [7:0] d);
    logic [15:0] e;
    for (int i = 0; i < 8; i++) e[2*i +: 2] = d[i] ? 2'b01 : 2'b10;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && rsp_valid_m && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else chk("rsp_rdata", rsp_rdata_m, exp_q.pop_front());
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready_m) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Called #1 after the accept edge of a write.
  task automatic check_write_seq(input logic [1:0] a, input logic [7:0] d);
    logic [15:0] enc;
    enc = tb_encode(d);
    ref_mem[sel][a] = d;
    for (int k = 1; k <= acc + 3; k++) begin
      @(negedge clk);
      chk("wr_wl", wl_m, (k >= 2 && k <= acc + 1) ? (4'b0001 << a) : 4'b0000);
      chk("wr_bl_oe", bl_oe_m, (k <= acc + 2) ? 1 : 0);
      chk("wr_bl", bl_m, (k <= acc + 2) ? enc : 16'h0);
      chk("wr_req_ready", req_ready_m, (k == acc + 3) ? 1 : 0);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    rsp_ready = 1'($urandom);
    wait_ready(ok);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 2'($urandom); req_wdata = 8'($urandom);
    if (ok) check_write_seq(a, d);
    rsp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, input int hold, input bit early,
                         input bit keep, input logic [1:0] na, input logic [7:0] nd);
    bit ok, got;
    logic [7:0] d0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'($urandom);
    rsp_ready = early;
    wait_ready(ok);
    @(posedge clk); #1;
    if (!ok) begin
      req_valid = 1'b0; rsp_ready = 1'b0;
      return;
    end
    if (keep) begin
      req_we = 1'b1; req_addr = na; req_wdata = nd;
    end else begin
      req_valid = 1'b0;
      req_we = 1'($urandom); req_addr = 2'($urandom); req_wdata = 8'($urandom);
    end
    exp_q.push_back(ref_mem[sel][a]);
    got = 1'b0;
    for (int k = 1; k <= acc + 6; k++) begin
      @(negedge clk);
      chk("rd_bl_oe", bl_oe_m, 0);
      chk("rd_bl", bl_m, 0);
      if (rsp_valid_m) begin
        chk("rd_latency", k, acc + 3);
        got = 1'b1;
        break;
      end
      chk("rd_wl", wl_m, (k >= 2 && k <= acc + 1) ? (4'b0001 << a) : 4'b0000);
    end
    if (!got) chk("rd_timeout", 0, 1);
    d0 = rsp_rdata_m;
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("bp_rsp_valid", rsp_valid_m, 1);
        chk("bp_rsp_rdata", rsp_rdata_m, d0);
        chk("bp_req_ready", req_ready_m, 0);
        chk("bp_wl", wl_m, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rd_ready_back", req_ready_m, 1);
    chk("rd_valid_clear", rsp_valid_m, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; acc = 1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // Requests under reset must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_valid = ~req_valid; req_we = 1'b1; req_addr = 2'(i);
      @(negedge clk);
      chk("rst_wl", wl_m, 0);
      chk("rst_bl", bl_m, 0);
      chk("rst_bl_oe", bl_oe_m, 0);
      chk("rst_rsp_valid", rsp_valid_m, 0);
      chk("rst_rsp_rdata", rsp_rdata_m, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready_m, 1);
    chk("rst_rsp_valid_after", rsp_valid_m, 0);

    do_write(2'd2, 8'hA5);
    do_write(2'd1, 8'h3C);
    do_read(2'd1, 0, 1'b0, 1'b0, 2'd0, 8'h00);
    do_write(2'd0, 8'h00);
    do_write(2'd3, 8'hC3);

    do_read(2'd2, 5, 1'b0, 1'b1, 2'd3, 8'h5E);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_write_seq(2'd3, 8'h5E);
    do_read(2'd3, 0, 1'b0, 1'b0, 2'd0, 8'h00);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(2'($urandom), 8'($urandom));
      else
        do_read(2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3) == 0, 1'b0, 2'd0, 8'h00);
    end

    sel = 1'b1; acc = 3;
    do_write(2'd3, 8'hFF);
    for (int r = 0; r < 3; r++) do_write(2'(r), 8'($urandom));
    do_read(2'd3, 2, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(2'($urandom), 8'($urandom));
      else
        do_read(2'($urandom), $urandom_range(0, 2), $urandom_range(0, 1) == 0, 1'b0, 2'd0, 8'h00);
    end

    // Reset while row 0 is selected during a write.
    sel = 1'b0; acc = 1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = 8'h96;
    begin
      bit ok;
      wait_ready(ok);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wl_before", wl_m, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_wl_async", wl_m, 0);
    chk("mid_bl_oe", bl_oe_m, 0);
    chk("mid_bl", bl_m, 0);
    chk("mid_req_ready", req_ready_m, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle_ready", req_ready_m, 1);
    chk("mid_idle_wl", wl_m, 0);
    do_write(2'd0, 8'h69);
    do_read(2'd0, 1, 1'b0, 1'b0, 2'd0, 8'h00);
    do_read(2'd1, 0, 1'b1, 1'b0, 2'd0, 8'h00);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
